// File: rtl/mod13_ctrl_pkg.sv
// Shared types and constants for the mod-13 counter command sequencer.
// Optional wrap-count output of the sequencer is enabled by MOD13_CTRL_WRAP_CNT_EN.
package mod13_ctrl_pkg;

  localparam int MOD = 13;
  localparam int W   = 4;

  // Largest value the counter can legally hold.
  localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // A LOAD value is usable only if the counter could actually hold it.
  function automatic logic is_legal_load(input logic [W-1:0] arg);
    return (arg <= MAX_VAL);
  endfunction

endpackage

// File: rtl/mod13_count_ctrl.sv
// Command sequencer for mod13_updown_counter.
// Takes NOP / LOAD / UP-by-N / DOWN-by-N commands over valid/ready and drives
// the counter's mode/load/data_in pins. Because the counter has no enable, it
// is held by reloading its own count whenever no command is executing.
// Optional feature macro: MOD13_CTRL_WRAP_CNT_EN adds the wrap_cnt output.
module mod13_count_ctrl
  import mod13_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,        // asynchronous, active-low
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  output logic         ctr_mode,
  output logic         ctr_load,
  output logic [W-1:0] ctr_data,
  input  logic [W-1:0] ctr_count,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef MOD13_CTRL_WRAP_CNT_EN
  ,
  output logic [W-1:0] wrap_cnt
`endif
);

  state_e       r_state;
  state_e       w_state_next;
  logic [W-1:0] r_rem;
  logic [W-1:0] w_rem_next;
  logic [W-1:0] r_arg;
  logic         r_dir;      // 1 = up, 0 = down
  logic         r_err;      // latched "illegal LOAD" flag for the current command
  logic         w_accept;
  op_e          w_op;

  assign w_op      = op_e'(cmd_op);
  // rst is included so the host never sees ready while the block is in reset.
  assign cmd_ready = (r_state == S_IDLE) && rst;
  assign w_accept  = cmd_valid && cmd_ready;

  // State and remaining-step registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
    end
  end

  // Capture the command fields at accept; they are ignored at all other times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arg <= '0;
      r_dir <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_arg <= cmd_arg;
      r_dir <= (w_op == OP_UP);
      r_err <= (w_op == OP_LOAD) && !is_legal_load(cmd_arg);
    end
  end

  // Next-state and step countdown.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_NOP:  w_state_next = S_DONE;
            OP_LOAD: w_state_next = is_legal_load(cmd_arg) ? S_LOAD : S_DONE;
            default: begin
              if (cmd_arg == '0) begin
                w_state_next = S_DONE;
              end else begin
                w_state_next = S_RUN;
                w_rem_next   = cmd_arg;
              end
            end
          endcase
        end
      end
      S_LOAD: w_state_next = S_DONE;
      S_RUN: begin
        w_rem_next = r_rem - W'(1);
        if (r_rem == W'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counter pin drive; outside LOAD/RUN the counter reloads its own value.
  always_comb begin
    ctr_load = 1'b1;
    ctr_data = ctr_count;
    ctr_mode = 1'b0;
    case (r_state)
      S_LOAD: ctr_data = r_arg;
      S_RUN: begin
        ctr_load = 1'b0;
        ctr_mode = r_dir;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = done && r_err;

`ifdef MOD13_CTRL_WRAP_CNT_EN
  logic [W-1:0] r_wrap_cnt;
  logic         w_wrap_hit;

  // The counter wraps on this RUN step if it sits at the end it is moving past.
  assign w_wrap_hit = r_dir ? (ctr_count == MAX_VAL) : (ctr_count == '0);

  // Count wraps during RUN, saturating; cleared when the next command is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap_cnt <= '0;
    end else if (w_accept) begin
      r_wrap_cnt <= '0;
    end else if ((r_state == S_RUN) && w_wrap_hit && (r_wrap_cnt != '1)) begin
      r_wrap_cnt <= r_wrap_cnt + W'(1);
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_mod13_count_ctrl.sv
// Scoreboard bench for mod13_count_ctrl with a behavioural mod-13 counter.
module tb_mod13_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_arg = 4'd0;
  logic       ctr_mode;
  logic       ctr_load;
  logic [3:0] ctr_data;
  logic [3:0] ctr_count = 4'd0;
  logic       busy;
  logic       done;
  logic       err;
`ifdef MOD13_CTRL_WRAP_CNT_EN
  logic [3:0] wrap_cnt;
`endif

  mod13_count_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .ctr_mode  (ctr_mode),
    .ctr_load  (ctr_load),
    .ctr_data  (ctr_data),
    .ctr_count (ctr_count),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MOD13_CTRL_WRAP_CNT_EN
    ,
    .wrap_cnt  (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Counter being sequenced: load wins, else up/down with mod-13 wrap.
  always @(posedge clk) begin
    if (ctr_load)      ctr_count <= ctr_data;
    else if (ctr_mode) ctr_count <= (ctr_count == 4'd12) ? 4'd0 : ctr_count + 4'd1;
    else               ctr_count <= (ctr_count == 4'd0) ? 4'd12 : ctr_count - 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cnt;
    int    err;
    int    wrap;
    int    dcyc;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, ".count"}, int'(ctr_count), e.cnt);
        chk({e.name, ".err"}, int'(err), e.err);
        chk({e.name, ".done_cycle"}, cyc, e.dcyc);
`ifdef MOD13_CTRL_WRAP_CNT_EN
        chk({e.name, ".wrap_cnt"}, int'(wrap_cnt), e.wrap);
`endif
      end
    end
    if (err && !done) begin
      n_vec++;
      n_miss++;
      $display("FAIL err_without_done: got err=1 done=0, expected err only with done");
    end
    if (ctr_load && ctr_data > 4'd12) begin
      n_vec++;
      n_miss++;
      $display("FAIL illegal_load_drive: got ctr_data=%0d with load, expected <=12", ctr_data);
    end
  end

  // Wait (bounded) until the controller is ready again; sampled #1 after posedge.
  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s.timeout: got cmd_ready=0 after 40 cycles, expected 1", name);
    end
  endtask

  // Present one command in the current cycle T; it is accepted at the next edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [3:0] arg,
                       input int ec, input int ee, input int ew, input int lat,
                       output int t);
    exp_t e;
    t = cyc;
    e.cnt = ec; e.err = ee; e.wrap = ew; e.dcyc = t + lat; e.name = name;
    q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int t;
    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cmd_ready", int'(cmd_ready), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.ctr_load", int'(ctr_load), 1);
    chk("rst.ctr_data", int'(ctr_data), 0);
    rst = 1'b1;
    #1;
    chk("rst_release.cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;

    // LOAD 5
    wait_ready("load5");
    issue("load5", 2'b01, 4'd5, 5, 0, 0, 2, t);
    chk("load5.t1_ctr_load", int'(ctr_load), 1);
    chk("load5.t1_ctr_data", int'(ctr_data), 5);
    wait_ready("load5");
    chk("load5.ready_cycle", cyc - t, 3);
    chk("load5.t3_busy", int'(busy), 0);

    // UP 10 from 5: 6..12,0,1,2 ; one wrap
    issue("up10", 2'b10, 4'd10, 2, 0, 1, 11, t);
    chk("up10.t1_ctr_load", int'(ctr_load), 0);
    chk("up10.t1_ctr_mode", int'(ctr_mode), 1);
    wait_ready("up10");

    // LOAD 1 then DOWN 3: 0,12,11 ; one wrap
    issue("load1", 2'b01, 4'd1, 1, 0, 0, 2, t);
    wait_ready("load1");
    issue("down3", 2'b11, 4'd3, 11, 0, 1, 4, t);
    chk("down3.t1_ctr_mode", int'(ctr_mode), 0);
    chk("down3.t1_ctr_load", int'(ctr_load), 0);
    wait_ready("down3");

    // Illegal LOAD 13: done+err at T+1, count unchanged, wrap cleared
    issue("load13", 2'b01, 4'd13, 11, 1, 0, 1, t);
    wait_ready("load13");

    // UP 0 and NOP complete immediately
    issue("up0", 2'b10, 4'd0, 11, 0, 0, 1, t);
    wait_ready("up0");
    issue("nop", 2'b00, 4'd0, 11, 0, 0, 1, t);
    wait_ready("nop");

    // cmd_valid held through DONE: second command only after the bubble
    issue("b2b_nop", 2'b00, 4'd0, 11, 0, 0, 1, t);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 4'd1;
    chk("b2b.t1_cmd_ready", int'(cmd_ready), 0);
    begin
      exp_t e;
      e.cnt = 12; e.err = 0; e.wrap = 0; e.dcyc = t + 4; e.name = "b2b_up1";
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("b2b.t2_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b.t3_busy", int'(busy), 1);
    wait_ready("b2b_up1");

    // LOAD 0, UP 8, reset at T+4 aborts (count 3 at that point)
    issue("load0", 2'b01, 4'd0, 0, 0, 0, 2, t);
    wait_ready("load0");
    issue("up8_abort", 2'b10, 4'd8, 8, 0, 0, 9, t);
    repeat (3) @(posedge clk);
    #1;
    chk("abort.pre_cycle", cyc - t, 4);
    rst = 1'b0;
    q.delete();
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.cmd_ready", int'(cmd_ready), 0);
    chk("abort.ctr_load", int'(ctr_load), 1);
    chk("abort.ctr_mode", int'(ctr_mode), 0);
    chk("abort.ctr_data", int'(ctr_data), 3);
    repeat (2) @(posedge clk);
    #1;
    chk("abort.held_count", int'(ctr_count), 3);
    rst = 1'b1;
    #1;
    chk("abort.release_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    issue("load9", 2'b01, 4'd9, 9, 0, 0, 2, t);
    wait_ready("load9");

    repeat (3) @(posedge clk);
    #1;
    chk("end.pending_expectations", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
